memory_unit: RTL and testbench
==============================

// Module: memory_unit
// PURPOSE
//  Memory (MEM) stage of the pipelined core: one packed command per cycle in,
//  one registered register-writeback word out. Holds a synchronous data RAM.
//  Performs stores, loads, or passes an ALU value straight to writeback.
//  Feeds the register-file write port.
// PARAMETERS
//  MEM_DEPTH  1024  data words in RAM (power of 2); address taken modulo MEM_DEPTH
//  DATA_W     16    RAM word / value width (fixed by command packing; do not change)
// PORTS
//  clk   in   1   sole clock; everything updates on posedge
//  rst   in   1   synchronous, active-high reset
//  Address_Value_RegAddress_isLoad_isMemWrite_isWrite  in  36  packed command:
//        [35:22] addr (14b)  [21:6] value (16b)  [5:3] reg_addr
//        [2] is_load  [1] is_mem_write  [0] is_write
//  write      out  11  writeback bus: [10] reg write enable, [9:7] dest reg,
//                      [6:0] result[6:0]
//  wb_data    out  16  full 16-bit writeback result (same cycle as write)
// BEHAVIOUR
//  - Latency: command sampled at posedge N; write/wb_data valid after posedge N.
//    Outputs are registered and held until the next edge. No handshake;
//    one command is accepted every cycle.
//  - Index: idx = addr mod MEM_DEPTH (upper address bits ignored; wrap-around).
//  - Store: is_mem_write=1 -> mem[idx] <= value at the sampling edge.
//  - Result:
//    - is_load=1 -> result = mem[idx] as it was before this edge
//      (read-before-write).
//    - otherwise result = value (pass-through).
//  - Simultaneous is_load and is_mem_write: the store is performed; result = old mem[idx].
//  - Outputs:
//    - is_write=1 -> write = {1, reg_addr, result[6:0]}; wb_data = result.
//    - is_write=0 -> write = 11'b0 and wb_data = 16'b0, even if a store occurs.
//  - Reset (rst=1 at posedge): write = 0 and wb_data = 0; command ignored
//    (no RAM write).
//  - Reset does not clear RAM contents. RAM is zero-initialised at time 0,
//    so unwritten locations read 16'h0000.
//  - Deasserting rst: the command present at the first non-reset edge is processed
//    normally.
//  - X/undriven command bits: no requirement. rst must be driven; it is not
//    defaulted internally.
// TESTING
//  1 rst=1 for 2 edges, any command -> write=0, wb_data=0; RAM unchanged (addr 5 still reads 0).
//  2 store addr=5 value=16'hABCD reg=1 ld=0 mw=1 w=1 -> next edge write={1,3'b001,7'h4D},
//    wb_data=16'hABCD; mem[5]=16'hABCD.
//  3 load addr=5 reg=1 ld=1 mw=0 w=1 -> write={1,3'b001,7'h4D}, wb_data=16'hABCD.
//  4 pass addr=2 value=16'h1234 reg=2 ld=0 mw=0 w=1 -> write={1,3'b010,7'h34},
//    wb_data=16'h1234; mem[2] unchanged.
//  5 store addr=1029 value=16'h00FF w=0, then load addr=5 -> first write=0;
//    load returns 16'h00FF (wrap).
//  6 ld=1 mw=1 addr=7 value=16'h5555 (mem[7]=0) -> wb_data=0, then load addr 7 -> 16'h5555;
//    assert rst mid-stream -> outputs 0 next edge.

Source files
------------

// File: rtl/memory_unit.sv
// rtl/memory_unit.sv - MEM pipeline stage: data RAM store/load plus registered register-writeback word
module memory_unit #(
    parameter int MEM_DEPTH = 1024,
    parameter int DATA_W    = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [35:0] Address_Value_RegAddress_isLoad_isMemWrite_isWrite,
    output logic [10:0] write,
    output logic [15:0] wb_data
);
    localparam int IDX_W = $clog2(MEM_DEPTH);

    logic [13:0]       cmd_addr;
    logic [15:0]       cmd_value;
    logic [2:0]        cmd_reg;
    logic              cmd_load;
    logic              cmd_mem_write;
    logic              cmd_write;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] result;
    logic              unused_addr_bits;

    logic [DATA_W-1:0] mem_q [MEM_DEPTH] = '{default: '0};
    logic [10:0]       write_q, write_d;
    logic [15:0]       wb_data_q, wb_data_d;

    assign cmd_addr      = Address_Value_RegAddress_isLoad_isMemWrite_isWrite[35:22];
    assign cmd_value     = Address_Value_RegAddress_isLoad_isMemWrite_isWrite[21:6];
    assign cmd_reg       = Address_Value_RegAddress_isLoad_isMemWrite_isWrite[5:3];
    assign cmd_load      = Address_Value_RegAddress_isLoad_isMemWrite_isWrite[2];
    assign cmd_mem_write = Address_Value_RegAddress_isLoad_isMemWrite_isWrite[1];
    assign cmd_write     = Address_Value_RegAddress_isLoad_isMemWrite_isWrite[0];

    // Address wraps modulo the RAM depth; the high address bits are simply dropped.
    assign idx              = cmd_addr[IDX_W-1:0];
    assign unused_addr_bits = ^cmd_addr[13:IDX_W];

    // Reading the array before the edge gives old data when a load and store collide.
    assign result = cmd_load ? mem_q[idx] : cmd_value;

    always_comb begin
        write_d   = 11'b0;
        wb_data_d = 16'b0;
        if (cmd_write) begin
            write_d   = {1'b1, cmd_reg, result[6:0]};
            wb_data_d = result;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && cmd_mem_write) begin
            mem_q[idx] <= cmd_value;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            write_q   <= 11'b0;
            wb_data_q <= 16'b0;
        end else begin
            write_q   <= write_d;
            wb_data_q <= wb_data_d;
        end
    end

    assign write   = write_q;
    assign wb_data = wb_data_q;
endmodule

// File: tb/tb_memory_unit.sv
// tb/tb_memory_unit.sv - self-checking bench for memory_unit with directed and random commands
module tb_memory_unit;
    logic        clk;
    logic        rst;
    logic [35:0] cmd;
    logic [10:0] write;
    logic [15:0] wb_data;

    int n_assert;
    int n_fail;

    logic [15:0] model_mem [1024];
    logic [10:0] exp_write;
    logic [15:0] exp_wb;

    memory_unit dut (
        .clk(clk),
        .rst(rst),
        .Address_Value_RegAddress_isLoad_isMemWrite_isWrite(cmd),
        .write(write),
        .wb_data(wb_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus; the expected outputs come from the array model.
    task automatic step(input logic r, input logic [13:0] a, input logic [15:0] v,
                        input logic [2:0] ra, input logic ld, input logic mw, input logic w);
        int idx;
        logic [15:0] res;
        rst = r;
        cmd = {a, v, ra, ld, mw, w};
        @(posedge clk);
        #1;
        exp_write = '0;
        exp_wb    = '0;
        if (!r) begin
            idx = int'(a) % 1024;
            res = ld ? model_mem[idx] : v;
            if (mw) model_mem[idx] = v;
            if (w) begin
                exp_write = {1'b1, ra, res[6:0]};
                exp_wb    = res;
            end
        end
        chk("write", 32'(write), 32'(exp_write));
        chk("wb_data", 32'(wb_data), 32'(exp_wb));
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        for (int i = 0; i < 1024; i++) model_mem[i] = 16'h0000;
        rst = 1'b1;
        cmd = '0;

        // reset holds outputs low and blocks the store
        step(1'b1, 14'd5, 16'hDEAD, 3'd1, 1'b0, 1'b1, 1'b1);
        step(1'b1, 14'd5, 16'hBEEF, 3'd1, 1'b1, 1'b1, 1'b1);
        chk("reset_write_const", 32'(write), 32'h0);
        step(1'b0, 14'd5, 16'h0000, 3'd1, 1'b1, 1'b0, 1'b1);
        chk("after_reset_mem5", 32'(wb_data), 32'h0000);

        step(1'b0, 14'd5, 16'hABCD, 3'd1, 1'b0, 1'b1, 1'b1);
        chk("store_write_const", 32'(write), 32'({1'b1, 3'b001, 7'h4D}));
        chk("store_wb_const", 32'(wb_data), 32'hABCD);

        step(1'b0, 14'd5, 16'h0000, 3'd1, 1'b1, 1'b0, 1'b1);
        chk("load_wb_const", 32'(wb_data), 32'hABCD);

        step(1'b0, 14'd2, 16'h1234, 3'd2, 1'b0, 1'b0, 1'b1);
        chk("pass_write_const", 32'(write), 32'({1'b1, 3'b010, 7'h34}));
        step(1'b0, 14'd2, 16'h0000, 3'd3, 1'b1, 1'b0, 1'b1);
        chk("pass_mem2_unchanged", 32'(wb_data), 32'h0000);

        step(1'b0, 14'd1029, 16'h00FF, 3'd4, 1'b0, 1'b1, 1'b0);
        chk("nowrite_store_write", 32'(write), 32'h0);
        step(1'b0, 14'd5, 16'h0000, 3'd4, 1'b1, 1'b0, 1'b1);
        chk("wrap_load_const", 32'(wb_data), 32'h00FF);

        step(1'b0, 14'd7, 16'h5555, 3'd5, 1'b1, 1'b1, 1'b1);
        chk("rbw_old_value", 32'(wb_data), 32'h0000);
        step(1'b0, 14'd7, 16'h0000, 3'd5, 1'b1, 1'b0, 1'b1);
        chk("rbw_new_value", 32'(wb_data), 32'h5555);
        step(1'b1, 14'd7, 16'h9999, 3'd6, 1'b0, 1'b1, 1'b1);
        chk("midstream_reset_wb", 32'(wb_data), 32'h0);
        step(1'b0, 14'd7, 16'h0000, 3'd6, 1'b1, 1'b0, 1'b1);
        chk("midstream_reset_no_store", 32'(wb_data), 32'h5555);

        // random traffic concentrated on a few indexes with random high address bits
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 19) == 0),
                 {4'($urandom), 10'($urandom_range(0, 15))},
                 16'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
